// File: rtl/prefetcher_pkg.sv
// Shared constants and FSM encoding for the instruction prefetch unit.
package prefetcher_pkg;
  localparam int REG_BITS    = 8;
  localparam int WORD_BITS   = 2 * REG_BITS;
  localparam int NSHIFT      = 2;
  localparam int CHUNKS      = WORD_BITS / NSHIFT;
  localparam int QUEUE_WORDS = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_WAIT_RX = 3'd3,
    ST_DATA    = 3'd4
  } pf_state_t;
endpackage

// File: rtl/prefetch_queue.sv
// Small circular FIFO holding prefetched instruction words.
module prefetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/prefetcher.sv
// Instruction prefetcher: owns the PC, fetches 16-bit words over the serial
// TX/RX links and hands them to the decoder or the imm16 register.
module prefetcher
  import prefetcher_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              block_prefetch,
  input  logic              write_pc_now,
  input  logic              ext_pc_next,
  input  logic [2:0]        comp_counter,
  input  logic [NSHIFT-1:0] pc_data_out,
  output logic [NSHIFT-1:0] pc_data_in,
  output logic              prefetch_idle,
  output logic              any_prefetched,
  input  logic              load_imm16,
  output logic              imm16_loaded,
  output logic [NSHIFT-1:0] imm_data_in,
  input  logic              next_imm_data,
  output logic [15:0]       imm_full,
  output logic [15:0]       inst_word,
  output logic              inst_word_valid,
  input  logic              inst_word_consume,
  output logic              pf_tx_req,
  input  logic              pf_tx_grant,
  input  logic              pf_tx_data_next,
  output logic [NSHIFT-1:0] pf_tx_data,
  input  logic              pf_rx_data_valid,
  input  logic              pf_rx_done,
  input  logic [NSHIFT-1:0] rx_pins,
  output logic [2:0]        dbg_state
);
  localparam int CW = $clog2(QUEUE_WORDS + 1);

  pf_state_t            state;
  logic [WORD_BITS-1:0] addr_sr;
  logic [2:0]           chunk_cnt;
  logic [WORD_BITS-1:0] rx_word;
  logic [WORD_BITS-1:0] pc;
  logic [WORD_BITS-1:0] imm;
  logic [CW-1:0]        q_count;
  logic [WORD_BITS-1:0] q_head;

  logic                 flush;
  logic                 imm_take;
  logic                 q_pop;
  logic                 q_push;
  logic                 start_fetch;
  logic [WORD_BITS-1:0] rx_shifted;

  // A jump completes on the last chunk of a PC write; the queue is then stale.
  assign flush       = ext_pc_next && write_pc_now && (comp_counter == 3'd7);
  assign imm_take    = load_imm16 && (q_count != '0) && !imm16_loaded;
  assign q_pop       = imm_take || inst_word_consume;
  assign rx_shifted  = {rx_pins, rx_word[WORD_BITS-1:NSHIFT]};
  assign q_push      = ((state == ST_WAIT_RX) || (state == ST_DATA)) &&
                       pf_rx_data_valid && pf_rx_done;
  // The imm16 pulse cycle holds back a slot so the scheduler sees a stable queue.
  assign start_fetch = !block_prefetch &&
                       ((int'(q_count) + int'(imm16_loaded)) < QUEUE_WORDS);

  prefetch_queue #(.DEPTH(QUEUE_WORDS), .WIDTH(WORD_BITS)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (rx_shifted),
    .pop       (q_pop),
    .flush     (flush),
    .head      (q_head),
    .count     (q_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      addr_sr   <= '0;
      chunk_cnt <= '0;
      rx_word   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_fetch) begin
            state     <= ST_REQ;
            addr_sr   <= pc + WORD_BITS'({q_count, 1'b0});
            chunk_cnt <= '0;
          end
        end
        ST_REQ: begin
          if (pf_tx_grant) state <= ST_ADDR;
        end
        ST_ADDR: begin
          if (pf_tx_data_next) begin
            addr_sr   <= addr_sr >> NSHIFT;
            chunk_cnt <= chunk_cnt + 3'd1;
            if (chunk_cnt == 3'd7) state <= ST_WAIT_RX;
          end
        end
        ST_WAIT_RX, ST_DATA: begin
          if (pf_rx_data_valid) begin
            rx_word <= rx_shifted;
            state   <= pf_rx_done ? ST_IDLE : ST_DATA;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= '0;
      imm          <= '0;
      imm16_loaded <= 1'b0;
    end else begin
      imm16_loaded <= imm_take;
      if (ext_pc_next)
        pc <= {(write_pc_now ? pc_data_out : pc[NSHIFT-1:0]), pc[WORD_BITS-1:NSHIFT]};
      else if (q_pop)
        pc <= pc + 16'd2;
      if (flush)
        imm <= '0;
      else if (imm_take)
        imm <= q_head;
      else if (next_imm_data)
        imm <= {imm[NSHIFT-1:0], imm[WORD_BITS-1:NSHIFT]};
    end
  end

  assign pc_data_in      = pc[NSHIFT-1:0];
  assign prefetch_idle   = (state == ST_IDLE);
  assign any_prefetched  = (q_count != '0);
  assign imm_data_in     = imm[NSHIFT-1:0];
  assign imm_full        = imm;
  assign inst_word       = q_head;
  assign inst_word_valid = any_prefetched && !load_imm16;
  assign pf_tx_req       = (state == ST_REQ);
  assign pf_tx_data      = (state == ST_ADDR) ? addr_sr[NSHIFT-1:0] : '0;
  assign dbg_state       = state;
endmodule
